// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for a raw switch bank; emits clean levels and rise/fall pulses.
// Optional interrupt pending/ack logic is built when SW_DEBOUNCE_IRQ_EN is defined.
module sw_debounce #(
  parameter int                 WIDTH         = 8,
  parameter int                 STABLE_CYCLES = 50000,
  parameter int                 CNT_W         = 16,
  parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`ifdef SW_DEBOUNCE_IRQ_EN
  output logic             irq,
  output logic [WIDTH-1:0] irq_pend,
  input  logic [WIDTH-1:0] irq_ack,
`endif
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  // A bit is accepted on the edge where it has already differed for STABLE_CYCLES-1 counted edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != sw_out[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Synchroniser stages
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Stability counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_out  <= RESET_VAL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_out  <= sw_out ^ accept;
      rise    <= accept & sync2;
      fall    <= accept & ~sync2;
      changed <= |accept;
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == sw_out[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  // Pending bits latch the registered pulses; a new event outranks a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= (irq_pend & ~irq_ack) | rise | fall;
      irq      <= |irq_pend;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios with literal expectations plus randomized
// switch activity compared every cycle against a sliding-window behavioural model.
module tb_sw_debounce;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out, rise, fall;
  logic         changed;
`ifdef SW_DEBOUNCE_IRQ_EN
  logic         irq;
  logic [W-1:0] irq_pend;
  logic [W-1:0] irq_ack;
`endif

  int checks = 0;
  int errors = 0;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(16), .RESET_VAL({W{1'b1}})) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .rise(rise),
    .fall(fall),
`ifdef SW_DEBOUNCE_IRQ_EN
    .irq(irq),
    .irq_pend(irq_pend),
    .irq_ack(irq_ack),
`endif
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Behavioural model: sw_in delayed by two edges, accepted when the last SC delayed samples
  // since reset all disagree with the current output.
  logic [W-1:0] m_d1, m_d2, m_out, m_rise, m_fall;
  logic         m_chg;
  logic [W-1:0] hist[$];
  logic [W-1:0] m_pend;
  logic         m_irq;
  bit           m_ok = 0;

  always @(posedge clk) begin
    logic [W-1:0] acc;
    bit all_diff;
    if (rst) begin
      m_d1 = '1; m_d2 = '1; m_out = '1;
      m_rise = '0; m_fall = '0; m_chg = 1'b0;
      m_pend = '0; m_irq = 1'b0;
      hist.delete();
      m_ok = 1;
    end else begin
      hist.push_back(m_d2);
      if (hist.size() > SC) void'(hist.pop_front());
      acc = '0;
      if (hist.size() == SC) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1;
          foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 0;
          acc[b] = all_diff;
        end
      end
`ifdef SW_DEBOUNCE_IRQ_EN
      m_irq  = |m_pend;
      m_pend = (m_pend & ~irq_ack) | m_rise | m_fall;
`endif
      m_rise = acc & m_d2;
      m_fall = acc & ~m_d2;
      m_chg  = |acc;
      m_out  = m_out ^ acc;
      m_d2   = m_d1;
      m_d1   = sw_in;
    end
  end

  task automatic cmp(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      cmp("sw_out", sw_out, m_out);
      cmp("rise", rise, m_rise);
      cmp("fall", fall, m_fall);
      cmp("changed", W'(changed), W'(m_chg));
`ifdef SW_DEBOUNCE_IRQ_EN
      cmp("irq_pend", irq_pend, m_pend);
      cmp("irq", W'(irq), W'(m_irq));
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(string name, logic [W-1:0] act, logic [W-1:0] mdl, logic [W-1:0] exp);
    cmp({name, "_dut"}, act, exp);
    cmp({name, "_model"}, mdl, exp);
  endtask

  initial begin
    rst = 1'b1;
    sw_in = 8'h00;
`ifdef SW_DEBOUNCE_IRQ_EN
    irq_ack = '0;
`endif
    @(negedge clk);
    tick(2);
    lit("rst_out", sw_out, m_out, 8'hFF);
    lit("rst_chg", W'(changed), W'(m_chg), 8'h00);
    rst = 1'b0;
    tick(5);
    lit("rel_hold", sw_out, m_out, 8'hFF);
    tick(1);
    lit("rel_acc", sw_out, m_out, 8'h00);
    lit("rel_fall", fall, m_fall, 8'hFF);
    tick(1);
    lit("rel_fall_end", fall, m_fall, 8'h00);
    sw_in = 8'hFF;
    tick(6);
    lit("all_rise", rise, m_rise, 8'hFF);
    tick(2);

    // clean step on bit 0
    sw_in = 8'hFE;
    tick(5);
    lit("step_hold", sw_out, m_out, 8'hFF);
    tick(1);
    lit("step_out", sw_out, m_out, 8'hFE);
    lit("step_fall", fall, m_fall, 8'h01);
    lit("step_chg", W'(changed), W'(m_chg), 8'h01);
    tick(1);
    lit("step_fall_end", fall, m_fall, 8'h00);
    sw_in = 8'hFF;
    tick(8);

    // bounce on bit 3: 3 low / 3 high, never long enough
    for (int p = 0; p < 4; p++) begin
      sw_in = 8'hF7; tick(3);
      sw_in = 8'hFF; tick(3);
    end
    lit("bounce_out", sw_out, m_out, 8'hFF);
    sw_in = 8'hF7;
    tick(5);
    lit("bounce_hold", sw_out, m_out, 8'hFF);
    tick(1);
    lit("bounce_acc", sw_out, m_out, 8'hF7);
    sw_in = 8'hFF;
    tick(8);

    // multi-bit simultaneous acceptance
    sw_in = 8'h0F;
    tick(6);
    lit("multi_out", sw_out, m_out, 8'h0F);
    lit("multi_fall", fall, m_fall, 8'hF0);
    tick(1);
    lit("multi_fall_end", fall, m_fall, 8'h00);
    sw_in = 8'hFF;
    tick(8);

    // reset mid-count on bit 7
    sw_in = 8'h7F;
    tick(4);
    rst = 1'b1;
    tick(1);
    lit("midrst_out", sw_out, m_out, 8'hFF);
    rst = 1'b0;
    tick(5);
    lit("midrst_hold", sw_out, m_out, 8'hFF);
    tick(1);
    lit("midrst_acc", sw_out, m_out, 8'h7F);
    sw_in = 8'hFF;
    tick(8);

`ifdef SW_DEBOUNCE_IRQ_EN
    irq_ack = 8'hFF; tick(2); irq_ack = '0; tick(1);
    sw_in = 8'hFB; tick(8);
    irq_ack = 8'h04; tick(1); irq_ack = '0; tick(1);
    sw_in = 8'hFF;
    tick(6);
    lit("irq_rise", rise, m_rise, 8'h04);
    tick(1);
    lit("irq_pend_set", irq_pend, m_pend, 8'h04);
    tick(1);
    lit("irq_up", W'(irq), W'(m_irq), 8'h01);
    irq_ack = 8'h04; tick(1); irq_ack = '0;
    lit("irq_pend_clr", irq_pend, m_pend, 8'h00);
    tick(1);
    lit("irq_down", W'(irq), W'(m_irq), 8'h00);
    sw_in = 8'hFB;
    tick(6);
    irq_ack = 8'h04; tick(1); irq_ack = '0;
    lit("irq_set_wins", irq_pend, m_pend, 8'h04);
    tick(4);
`endif

    // randomized activity: sparse bit flips, bursts of bounce, rare resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) sw_in[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) sw_in = W'($urandom);
      rst = ($urandom_range(0, 499) == 0);
`ifdef SW_DEBOUNCE_IRQ_EN
      irq_ack = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Input conditioning stage placed directly upstream of the soc top. It takes the raw, asynchronous DIP-switch bank (SW3) and drives the soc's switch inputs.
- Each bit is synchronised into clk, debounced with a per-bit stability counter, and registered as a clean level.
- A one-cycle rise/fall pulse accompanies each accepted transition.
- Switch-sourced reset and mode bits therefore reach the core glitch-free.

Parameters:
WIDTH, 8, number of switch bits conditioned.
STABLE_CYCLES, 50000, consecutive cycles a synchronised bit must differ from the current output before the change is accepted (must be >= 1).
CNT_W, 16, stability counter width; 2**CNT_W must be > STABLE_CYCLES-1.
RESET_VAL, {WIDTH{1'b1}}, value of sw_out and of both synchroniser stages after reset.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  synchronous active-high reset.
sw_in  input  WIDTH  raw asynchronous switch levels.
sw_out  output  WIDTH  debounced, clk-synchronous switch levels.
rise  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 0->1.
fall  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 1->0.
changed  output  1  OR-reduction of rise|fall, same cycle.

Behaviour:
- Reset (rst high at a clk edge):
  - sync1, sync2 and sw_out load RESET_VAL.
  - All counters load 0.
  - rise, fall and changed are 0.
  - rst takes priority over every other event, including a pending acceptance on the same edge.
  - Reset mid-count discards the partial count.
- Synchroniser: two flops per bit, sync1 <= sw_in, sync2 <= sync1. Only sync2 is used downstream.
- Per-bit counter cnt[i], evaluated on each edge:
  - If sync2[i] == sw_out[i]: cnt[i] <= 0. Any bounce restarts the count.
  - Else if cnt[i] == STABLE_CYCLES-1:
    - sw_out[i] <= sync2[i].
    - cnt[i] <= 0.
    - rise[i] or fall[i] asserts for exactly the next cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Counter arithmetic: unsigned, never exceeds STABLE_CYCLES-1, no wrap.
- STABLE_CYCLES == 1: accepts on the first cycle sync2 differs.
- Latency from a clean sw_in step to sw_out change: 2 (sync) + STABLE_CYCLES clk edges. rise/fall is visible in the same cycle as the new sw_out value.
- Bits are fully independent. Simultaneous acceptances on several bits pulse in the same cycle.
- rise/fall are registered outputs and deassert the cycle after acceptance unless that bit is accepted again, which is impossible since at least STABLE_CYCLES cycles separate acceptances.
- No combinational path from sw_in to any output.

Optional Feature:
Macro SW_DEBOUNCE_IRQ_EN.
- Defined: adds ports irq (output, 1), irq_pend (output, WIDTH) and irq_ack (input, WIDTH).
  - irq_pend[i] is set on rise[i]|fall[i] and cleared when irq_ack[i] is 1.
  - Set wins over a same-cycle ack.
  - irq = |irq_pend, registered.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Test Plan:
1. Reset value: WIDTH=8, STABLE_CYCLES=4. rst high 2 cycles with sw_in=8'h00 -> sw_out=8'hFF, rise/fall/changed=0 during and after reset until acceptance.
2. Clean step: sw_in[0] 1->0, held -> sw_out[0]=0 exactly 6 edges later; fall[0]=1 for exactly 1 cycle; changed=1 that cycle.
3. Bounce rejection:
   - sw_in[3] toggles with period 6 cycles (high 3, low 3) -> sw_out[3] stays 1, no pulses.
   - After sw_in[3] is held 0 -> accepted 6 edges after the last edge.
4. Multi-bit: sw_in 8'hFF->8'h0F in one cycle -> sw_out=8'h0F and fall=8'hF0 in the same single cycle.
5. Reset mid-count: start sw_in[7] 1->0, assert rst at count 2 -> sw_out[7]=1. After release with sw_in[7]=0 held -> acceptance a full 6 edges after rst deasserts.
6. With SW_DEBOUNCE_IRQ_EN:
   - Accept a rise on bit 2 -> irq_pend=8'h04, irq=1 one cycle later.
   - irq_ack=8'h04 -> irq_pend=0, irq=0.
   - Ack coincident with a new bit-2 event -> irq_pend[2] stays 1.
